// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_BITS data bits, optional parity, 1-2 stop bits.
// An internal baud counter sets the bit timing on tx_Clk. Every output is a register.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic                 tx_Clk,
    input  logic                 tx_Rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 out_bit,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int IW    = $clog2(DATA_BITS);
    localparam int NSTOP = (STOP_BITS == 2) ? 2 : 1;
    localparam logic HAS_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam logic ODD_PAR = (PARITY_MODE == 2);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(NSTOP - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        baud, baud_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 par, par_nx;
    logic                 bit_end;
    logic                 out_nx, ready_nx, busy_nx, done_nx;

    always_ff @(posedge tx_Clk) begin
        if (!tx_Rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            idx      <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            out_bit  <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            baud     <= baud_nx;
            idx      <= idx_nx;
            shreg    <= shreg_nx;
            par      <= par_nx;
            out_bit  <= out_nx;
            tx_ready <= ready_nx;
            tx_busy  <= busy_nx;
            tx_done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        idx_nx   = idx;
        shreg_nx = shreg;
        par_nx   = par;
        done_nx  = 1'b0;
        bit_end  = (baud == BAUD_LAST);

        if (state != IDLE)
            baud_nx = bit_end ? '0 : baud + 1'b1;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_nx = i_tx_data;
                    par_nx   = (^i_tx_data) ^ ODD_PAR;
                    baud_nx  = '0;
                    idx_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    // The bit on the line is always at the outgoing end of shreg.
                    shreg_nx = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
                    if (idx == DATA_LAST) begin
                        idx_nx   = '0;
                        state_nx = HAS_PAR ? PARITY : STOP;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_nx = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        idx_nx   = '0;
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // The line level follows the next state so that out_bit is registered.
        out_nx = 1'b1;
        case (state_nx)
            START:   out_nx = 1'b0;
            DATA:    out_nx = (LSB_FIRST != 0) ? shreg_nx[0] : shreg_nx[DATA_BITS-1];
            PARITY:  out_nx = par_nx;
            default: out_nx = 1'b1;
        endcase

        ready_nx = (state_nx == IDLE);
        busy_nx  = (state_nx != IDLE);
    end
endmodule
